// File: rtl/mem_rsp_cut_pkg.sv
// Shared types and sizing helpers for the memory-island response cut array.
package mem_rsp_cut_pkg;

    typedef enum logic {
        CUT_SPILL = 1'b0,
        CUT_PIPE  = 1'b1
    } cut_mode_e;

    function automatic int unsigned max_entries(input int unsigned cuts, input cut_mode_e mode);
        return (mode == CUT_SPILL) ? cuts * 2 : cuts;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_ent);
        return (max_ent == 0) ? 1 : unsigned'($clog2(max_ent + 1));
    endfunction

endpackage

// File: rtl/mem_rsp_cut_stage.sv
// One valid/ready register stage: 2-entry spill (cuts ready) or 1-entry pipe (ready stays combinational).
module mem_rsp_cut_stage
    import mem_rsp_cut_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter cut_mode_e   CutMode   = CUT_SPILL
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic [1:0]           fill_o
);

    if (CutMode == CUT_SPILL) begin : g_spill
        logic                 r_a_vld, r_b_vld;
        logic [DataWidth-1:0] r_a_data, r_b_data;
        logic                 w_push, w_pop;

        assign ready_o = !r_b_vld;
        assign w_push  = valid_i && !r_b_vld;
        assign w_pop   = r_a_vld && ready_i;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_a_vld <= 1'b0;
                r_b_vld <= 1'b0;
            end else if (flush_i) begin
                r_a_vld <= 1'b0;
                r_b_vld <= 1'b0;
            end else if (w_pop) begin
                // B full implies no push this cycle, so B simply shifts into A
                if (r_b_vld) begin
                    r_a_vld <= 1'b1;
                    r_b_vld <= 1'b0;
                end else begin
                    r_a_vld <= w_push;
                end
            end else if (w_push) begin
                if (r_a_vld) r_b_vld <= 1'b1;
                else         r_a_vld <= 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (w_pop && r_b_vld)                  r_a_data <= r_b_data;
            else if (w_push && (w_pop || !r_a_vld)) r_a_data <= data_i;
            if (w_push && r_a_vld && !w_pop)        r_b_data <= data_i;
        end

        assign valid_o = r_a_vld;
        assign data_o  = r_a_data;
        assign fill_o  = {1'b0, r_a_vld} + {1'b0, r_b_vld};
    end else begin : g_pipe
        logic                 r_vld;
        logic [DataWidth-1:0] r_data;
        logic                 w_push;

        assign ready_o = !r_vld || ready_i;
        assign w_push  = valid_i && ready_o;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)      r_vld <= 1'b0;
            else if (flush_i) r_vld <= 1'b0;
            else if (w_push)  r_vld <= 1'b1;
            else if (ready_i) r_vld <= 1'b0;
        end

        always_ff @(posedge clk_i) begin
            if (w_push) r_data <= data_i;
        end

        assign valid_o = r_vld;
        assign data_o  = r_data;
        assign fill_o  = {1'b0, r_vld};
    end

endmodule

// File: rtl/mem_rsp_cut_array.sv
// Per-channel chains of response cut stages with flush gating and occupancy reporting.
module mem_rsp_cut_array
    import mem_rsp_cut_pkg::*;
#(
    parameter int unsigned  DataWidth   = 32,
    parameter int unsigned  NumChannels = 1,
    parameter int unsigned  NumCuts     = 1,
    parameter cut_mode_e    CutMode     = CUT_SPILL,
    localparam int unsigned MaxEntries  = max_entries(NumCuts, CutMode),
    localparam int unsigned CntWidth    = cnt_width(MaxEntries)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   flush_i,
    input  logic [NumChannels-1:0]                 rvalid_i,
    output logic [NumChannels-1:0]                 rready_o,
    input  logic [NumChannels-1:0][DataWidth-1:0]  rdata_i,
    output logic [NumChannels-1:0]                 rvalid_o,
    input  logic [NumChannels-1:0]                 rready_i,
    output logic [NumChannels-1:0][DataWidth-1:0]  rdata_o,
    output logic [NumChannels-1:0][CntWidth-1:0]   occupancy_o,
    output logic                                   idle_o
);

    logic [NumChannels-1:0] w_ch_idle;

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        if (NumCuts == 0) begin : g_bypass
            assign rvalid_o[c]    = rvalid_i[c] && !flush_i;
            assign rready_o[c]    = rready_i[c] && !flush_i;
            assign rdata_o[c]     = rdata_i[c];
            assign occupancy_o[c] = '0;
        end else begin : g_cuts
            logic [NumCuts:0]     w_vld, w_rdy;
            logic [DataWidth-1:0] w_data [NumCuts+1];
            logic [1:0]           w_fill [NumCuts];
            logic [CntWidth-1:0]  w_occ;

            // Gating at the boundary only: internal stages are cleared by flush anyway
            assign w_vld[0]       = rvalid_i[c] && !flush_i;
            assign w_data[0]      = rdata_i[c];
            assign rready_o[c]    = w_rdy[0] && !flush_i;
            assign rvalid_o[c]    = w_vld[NumCuts] && !flush_i;
            assign rdata_o[c]     = w_data[NumCuts];
            assign w_rdy[NumCuts] = rready_i[c];

            for (genvar s = 0; s < NumCuts; s++) begin : g_stage
                mem_rsp_cut_stage #(
                    .DataWidth (DataWidth),
                    .CutMode   (CutMode)
                ) u_stage (
                    .clk_i   (clk_i),
                    .rst_ni  (rst_ni),
                    .flush_i (flush_i),
                    .valid_i (w_vld[s]),
                    .ready_o (w_rdy[s]),
                    .data_i  (w_data[s]),
                    .valid_o (w_vld[s+1]),
                    .ready_i (w_rdy[s+1]),
                    .data_o  (w_data[s+1]),
                    .fill_o  (w_fill[s])
                );
            end

            always_comb begin
                w_occ = '0;
                for (int s = 0; s < NumCuts; s++) begin
                    w_occ = w_occ + CntWidth'(w_fill[s]);
                end
            end

            assign occupancy_o[c] = w_occ;
        end

        assign w_ch_idle[c] = (occupancy_o[c] == '0);
    end

    assign idle_o = &w_ch_idle;

endmodule

// File: tb/tb_mem_rsp_cut_array.sv
// Directed bench: 3-cut spill (2 channels), 2-cut pipe, and a zero-cut bypass instance.
module tb_mem_rsp_cut_array;
    import mem_rsp_cut_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             s_flush;
    logic [1:0]       s_vld_i, s_rdy_o, s_vld_o, s_rdy_i;
    logic [1:0][31:0] s_data_i, s_data_o;
    logic [1:0][2:0]  s_occ;
    logic             s_idle;

    logic             p_flush;
    logic [0:0]       p_vld_i, p_rdy_o, p_vld_o, p_rdy_i;
    logic [0:0][31:0] p_data_i, p_data_o;
    logic [0:0][1:0]  p_occ;
    logic             p_idle;

    logic             c_flush;
    logic [0:0]       c_vld_i, c_rdy_o, c_vld_o, c_rdy_i;
    logic [0:0][7:0]  c_data_i, c_data_o;
    logic [0:0][0:0]  c_occ;
    logic             c_idle;

    mem_rsp_cut_array #(.DataWidth(32), .NumChannels(2), .NumCuts(3), .CutMode(CUT_SPILL)) u_spill (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(s_flush),
        .rvalid_i(s_vld_i), .rready_o(s_rdy_o), .rdata_i(s_data_i),
        .rvalid_o(s_vld_o), .rready_i(s_rdy_i), .rdata_o(s_data_o),
        .occupancy_o(s_occ), .idle_o(s_idle)
    );

    mem_rsp_cut_array #(.DataWidth(32), .NumChannels(1), .NumCuts(2), .CutMode(CUT_PIPE)) u_pipe (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(p_flush),
        .rvalid_i(p_vld_i), .rready_o(p_rdy_o), .rdata_i(p_data_i),
        .rvalid_o(p_vld_o), .rready_i(p_rdy_i), .rdata_o(p_data_o),
        .occupancy_o(p_occ), .idle_o(p_idle)
    );

    mem_rsp_cut_array #(.DataWidth(8), .NumChannels(1), .NumCuts(0), .CutMode(CUT_SPILL)) u_comb (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(c_flush),
        .rvalid_i(c_vld_i), .rready_o(c_rdy_o), .rdata_i(c_data_i),
        .rvalid_o(c_vld_o), .rready_i(c_rdy_i), .rdata_o(c_data_o),
        .occupancy_o(c_occ), .idle_o(c_idle)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q [$];
    logic [31:0] exp_d;
    int got, acc, first_cyc, last_cyc, pushed, popped, found;
    logic [31:0] seen;

    initial begin
        rst_n = 1'b0;
        s_flush = 0; s_vld_i = '0; s_rdy_i = '0; s_data_i = '0;
        p_flush = 0; p_vld_i = '0; p_rdy_i = '0; p_data_i = '0;
        c_flush = 0; c_vld_i = '0; c_rdy_i = '0; c_data_i = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // reset state
        check_eq("rst_s_vld",  64'(s_vld_o), 64'(0));
        check_eq("rst_s_occ",  64'(s_occ),   64'(0));
        check_eq("rst_s_idle", 64'(s_idle),  64'(1));
        check_eq("rst_s_rdy",  64'(s_rdy_o), 64'(2'b11));
        check_eq("rst_p_rdy",  64'(p_rdy_o), 64'(1));
        check_eq("rst_p_idle", 64'(p_idle),  64'(1));

        // 1: stream 16 beats through 3 spill cuts
        s_rdy_i = 2'b11;
        exp_d = 32'h1; got = 0; first_cyc = -1; last_cyc = -1;
        for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
            if (cyc < 16) begin
                s_vld_i = 2'b01;
                s_data_i[0] = 32'(cyc + 1);
            end else begin
                s_vld_i = 2'b00;
            end
            #1;
            check_eq("t1_ch1_vld", 64'(s_vld_o[1]), 64'(0));
            if (cyc < 16) check_eq("t1_rdy", 64'(s_rdy_o[0]), 64'(1));
            if (s_vld_o[0]) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                check_eq("t1_data", 64'(s_data_o[0]), 64'(exp_d));
                exp_d++;
                got++;
            end
            tick();
        end
        s_vld_i = 2'b00;
        check_eq("t1_count", 64'(got), 64'(16));
        check_eq("t1_first", 64'(first_cyc), 64'(3));
        check_eq("t1_last",  64'(last_cyc),  64'(18));

        // 2: stall capacity
        s_rdy_i = 2'b10; acc = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            s_vld_i = 2'b01;
            s_data_i[0] = 32'h21 + 32'(acc);
            #1;
            if (!s_rdy_o[0]) break;
            acc++;
            tick();
        end
        s_vld_i = 2'b00;
        #1;
        check_eq("t2_accepted", 64'(acc),      64'(6));
        check_eq("t2_occ0",     64'(s_occ[0]), 64'(6));
        check_eq("t2_occ1",     64'(s_occ[1]), 64'(0));
        check_eq("t2_rdy",      64'(s_rdy_o[0]), 64'(0));
        check_eq("t2_idle",     64'(s_idle),   64'(0));
        s_rdy_i = 2'b11; got = 0;
        for (int cyc = 0; cyc < 20 && got < 6; cyc++) begin
            #1;
            if (s_vld_o[0]) begin
                check_eq("t2_drain", 64'(s_data_o[0]), 64'(32'h21 + 32'(got)));
                got++;
            end
            tick();
        end
        #1;
        check_eq("t2_drained", 64'(got),    64'(6));
        check_eq("t2_idle_end", 64'(s_idle), 64'(1));

        // 4: flush with 4 / 2 beats held
        tick();
        s_rdy_i = 2'b00;
        for (int i = 0; i < 4; i++) begin
            s_vld_i = {(i < 2) ? 1'b1 : 1'b0, 1'b1};
            s_data_i[0] = 32'h50 + 32'(i);
            s_data_i[1] = 32'h60 + 32'(i);
            tick();
        end
        s_vld_i = 2'b00;
        #1;
        check_eq("t4_occ0", 64'(s_occ[0]), 64'(4));
        check_eq("t4_occ1", 64'(s_occ[1]), 64'(2));
        s_flush = 1; s_vld_i = 2'b11; s_rdy_i = 2'b11;
        s_data_i[0] = 32'h5F; s_data_i[1] = 32'h6F;
        #1;
        check_eq("t4_fl_rdy", 64'(s_rdy_o), 64'(0));
        check_eq("t4_fl_vld", 64'(s_vld_o), 64'(0));
        tick();
        s_flush = 0; s_vld_i = 2'b00;
        #1;
        check_eq("t4_post_occ", 64'(s_occ),   64'(0));
        check_eq("t4_post_vld", 64'(s_vld_o), 64'(0));
        s_vld_i = 2'b01; s_data_i[0] = 32'hAA;
        tick();
        s_vld_i = 2'b00;
        found = 0; seen = '0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (s_vld_o[0]) begin
                found = 1;
                seen = s_data_o[0];
                break;
            end
            tick();
        end
        check_eq("t4_found", 64'(found), 64'(1));
        check_eq("t4_first", 64'(seen),  64'(32'hAA));
        tick();
        #1;
        check_eq("t4_idle", 64'(s_idle), 64'(1));

        // 5: async reset with 5 beats held
        s_rdy_i = 2'b00;
        for (int i = 0; i < 5; i++) begin
            s_vld_i = 2'b01;
            s_data_i[0] = 32'h70 + 32'(i);
            tick();
        end
        s_vld_i = 2'b00;
        #1;
        check_eq("t5_occ_pre", 64'(s_occ[0]), 64'(5));
        rst_n = 1'b0;
        #1;
        check_eq("t5_vld",  64'(s_vld_o), 64'(0));
        check_eq("t5_occ",  64'(s_occ),   64'(0));
        check_eq("t5_idle", 64'(s_idle),  64'(1));
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("t5_rdy", 64'(s_rdy_o), 64'(2'b11));

        // 3: pipe mode, ready passthrough and toggled ready
        p_rdy_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            p_vld_i = 1'b1;
            p_data_i[0] = 32'h31 + 32'(i);
            #1;
            if (p_rdy_o[0]) q.push_back(p_data_i[0]);
            tick();
        end
        p_vld_i = 1'b0;
        #1;
        check_eq("t3_acc",  64'(q.size()), 64'(2));
        check_eq("t3_occ",  64'(p_occ[0]), 64'(2));
        p_rdy_i = 1'b1;
        #1;
        check_eq("t3_rdy_hi", 64'(p_rdy_o), 64'(1));
        p_rdy_i = 1'b0;
        #1;
        check_eq("t3_rdy_lo", 64'(p_rdy_o), 64'(0));
        pushed = 2; popped = 0;
        tick();
        for (int cyc = 0; cyc < 30; cyc++) begin
            p_vld_i = 1'b1;
            p_data_i[0] = 32'h40 + 32'(pushed);
            p_rdy_i = 1'(cyc % 2);
            #1;
            if (p_vld_o[0] && p_rdy_i[0]) begin
                if (q.size() == 0) begin
                    check_eq("t3_dup", 64'(p_data_o[0]), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_d = q.pop_front();
                    check_eq("t3_data", 64'(p_data_o[0]), 64'(exp_d));
                end
                popped++;
            end
            if (p_rdy_o[0]) begin
                q.push_back(p_data_i[0]);
                pushed++;
            end
            tick();
        end
        p_vld_i = 1'b0; p_rdy_i = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (p_vld_o[0]) begin
                if (q.size() == 0) begin
                    check_eq("t3_dup", 64'(p_data_o[0]), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_d = q.pop_front();
                    check_eq("t3_drain", 64'(p_data_o[0]), 64'(exp_d));
                end
                popped++;
            end
            tick();
        end
        check_eq("t3_q_empty", 64'(q.size()), 64'(0));
        check_eq("t3_balance", 64'(popped),   64'(pushed));
        check_eq("t3_occ_end", 64'(p_occ[0]), 64'(0));

        // 6: zero-cut bypass
        for (int i = 0; i < 24; i++) begin
            c_flush = (i % 5 == 3);
            c_vld_i = c_flush ? 1'b1 : 1'($urandom_range(0, 1));
            c_rdy_i = c_flush ? 1'b1 : 1'($urandom_range(0, 1));
            c_data_i[0] = 8'($urandom);
            #1;
            check_eq("t6_data", 64'(c_data_o[0]), 64'(c_data_i[0]));
            check_eq("t6_vld",  64'(c_vld_o),     64'(c_vld_i[0] & ~c_flush));
            check_eq("t6_rdy",  64'(c_rdy_o),     64'(c_rdy_i[0] & ~c_flush));
            check_eq("t6_occ",  64'(c_occ[0]),    64'(0));
            check_eq("t6_idle", 64'(c_idle),      64'(1));
            tick();
        end
        c_flush = 0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
